// File: rtl/seg_scan_ctrl.sv
// Four-digit 7-segment scan scheduler with per-slot blanking and frame-aligned updates.
// Optional DIMMING_EN adds a bright_i input and per-ON-cycle PWM gating.
module seg_scan_ctrl #(
   parameter int unsigned SLOT_CYCLES  = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        upd_valid_i,
   output logic        upd_ready_o,
   input  logic [15:0] upd_data_i,
   input  logic [3:0]  upd_mask_i,
`ifdef DIMMING_EN
   input  logic [3:0]  bright_i,
`endif
   output logic [6:0]  segs_o,
   output logic [3:0]  an_o,
   output logic        frame_done_o
);

   localparam int unsigned CntW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

   typedef enum logic {StBlank, StOn} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   slot_cnt_q, slot_cnt_d;
   logic [1:0]        digit_q;
   logic [15:0]       active_data_q, pend_data_q;
   logic [3:0]        active_mask_q, pend_mask_q;
   logic              pend_valid_q, pend_valid_d;
   logic              ready_q;
   logic [6:0]        segs_q;
   logic [3:0]        an_q;
   logic              slot_last, frame_last, accept, lit;
   logic [3:0]        cur_nib;
`ifdef DIMMING_EN
   logic [3:0]        pwm_q, pwm_d;
   logic [3:0]        active_bright_q, pend_bright_q;
`endif

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         4'hF: s = 7'b0111000;
      endcase
      return s;
   endfunction

   always_comb begin
      slot_last  = (slot_cnt_q == CntW'(SLOT_CYCLES - 1));
      frame_last = slot_last && (digit_q == 2'd3);
      slot_cnt_d = slot_last ? '0 : slot_cnt_q + 1'b1;
      state_d    = (32'(slot_cnt_d) < BLANK_CYCLES) ? StBlank : StOn;
      accept     = upd_valid_i & ready_q;
      cur_nib    = active_data_q[{digit_q, 2'b00} +: 4];
      lit        = (state_q == StOn) && active_mask_q[digit_q];
`ifdef DIMMING_EN
      lit   = lit && ((active_bright_q == 4'hF) || (pwm_q < active_bright_q));
      // PWM phase restarts at every ON start, including a wrap when there is no blank phase
      pwm_d = (slot_cnt_d == '0) ? 4'd0 : ((state_q == StOn) ? pwm_q + 4'd1 : 4'd0);
`endif
      // A boundary drains pending; only an empty pending register can accept
      pend_valid_d = pend_valid_q;
      if (frame_last && pend_valid_q) begin
         pend_valid_d = 1'b0;
      end else if (accept) begin
         pend_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= (BLANK_CYCLES == 0) ? StOn : StBlank;
         slot_cnt_q    <= '0;
         digit_q       <= 2'd0;
         active_data_q <= 16'h0000;
         active_mask_q <= 4'h0;
         pend_data_q   <= 16'h0000;
         pend_mask_q   <= 4'h0;
         pend_valid_q  <= 1'b0;
         ready_q       <= 1'b0;
         segs_q        <= 7'h7F;
         an_q          <= 4'hF;
`ifdef DIMMING_EN
         pwm_q           <= 4'd0;
         active_bright_q <= 4'd0;
         pend_bright_q   <= 4'd0;
`endif
      end else begin
         state_q      <= state_d;
         slot_cnt_q   <= slot_cnt_d;
         if (slot_last) begin
            digit_q <= digit_q + 2'd1;
         end
         segs_q       <= lit ? seg_decode(cur_nib) : 7'h7F;
         an_q         <= lit ? ~(4'b0001 << digit_q) : 4'hF;
         pend_valid_q <= pend_valid_d;
         ready_q      <= ~pend_valid_d;
`ifdef DIMMING_EN
         pwm_q        <= pwm_d;
`endif
         if (frame_last && pend_valid_q) begin
            active_data_q <= pend_data_q;
            active_mask_q <= pend_mask_q;
`ifdef DIMMING_EN
            active_bright_q <= pend_bright_q;
`endif
         end else if (accept) begin
            pend_data_q <= upd_data_i;
            pend_mask_q <= upd_mask_i;
`ifdef DIMMING_EN
            pend_bright_q <= bright_i;
`endif
         end
      end
   end

   assign upd_ready_o  = ready_q;
   assign segs_o       = segs_q;
   assign an_o         = an_q;
   assign frame_done_o = frame_last;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle-indexed behavioural model plus directed literal checks.
module tb_seg_scan_ctrl;

   localparam int unsigned SLOT  = 8;
   localparam int unsigned BLANK = 2;
   localparam int unsigned FRAME = 4 * SLOT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        upd_valid = 1'b0;
   logic [15:0] upd_data = 16'h0000;
   logic [3:0]  upd_mask = 4'h0;
`ifdef DIMMING_EN
   logic [3:0]  bright = 4'h0;
`endif
   logic        upd_ready;
   logic [6:0]  segs;
   logic [3:0]  an;
   logic        frame_done;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .SLOT_CYCLES  (SLOT),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .upd_valid_i  (upd_valid),
      .upd_ready_o  (upd_ready),
      .upd_data_i   (upd_data),
      .upd_mask_i   (upd_mask),
`ifdef DIMMING_EN
      .bright_i     (bright),
`endif
      .segs_o       (segs),
      .an_o         (an),
      .frame_done_o (frame_done)
   );

   logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

   // k counts edges since reset; outputs visible at k describe scan position k-1
   int          k = 0;
   logic        started = 1'b0;
   logic [15:0] m_act_d = '0, m_pend_d = '0;
   logic [3:0]  m_act_m = '0, m_pend_m = '0, m_act_b = '0, m_pend_b = '0;
   logic        m_pend_v = 1'b0, m_ready = 1'b0;
   logic [6:0]  exp_segs = 7'h7F;
   logic [3:0]  exp_an = 4'hF;
   logic        exp_fd = 1'b0;

   always @(posedge clk) begin
      int   cnt, dig;
      logic on;
      if (rst) begin
         k = 0;
         m_act_d = '0; m_act_m = '0; m_act_b = '0;
         m_pend_v = 1'b0; m_ready = 1'b0;
         exp_segs = 7'h7F; exp_an = 4'hF; exp_fd = 1'b0;
         started = 1'b1;
      end else begin
         cnt = k % SLOT;
         dig = (k / SLOT) % 4;
         on  = (cnt >= BLANK) && m_act_m[dig];
`ifdef DIMMING_EN
         on  = on && ((m_act_b == 4'hF) || ((cnt - BLANK) % 16 < int'(m_act_b)));
`endif
         exp_an   = 4'hF;
         exp_segs = 7'h7F;
         if (on) begin
            exp_an[dig] = 1'b0;
            exp_segs    = seg_tab[m_act_d[dig*4 +: 4]];
         end
         if ((k % FRAME) == FRAME - 1 && m_pend_v) begin
            m_act_d = m_pend_d; m_act_m = m_pend_m; m_act_b = m_pend_b;
            m_pend_v = 1'b0;
         end else if (upd_valid && m_ready) begin
            m_pend_d = upd_data; m_pend_m = upd_mask;
`ifdef DIMMING_EN
            m_pend_b = bright;
`endif
            m_pend_v = 1'b1;
         end
         m_ready = !m_pend_v;
         k++;
         exp_fd = (k % FRAME) == FRAME - 1;
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s at k=%0d: got %h, expected %h", name, k, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         check("model_segs", 16'(segs), 16'(exp_segs));
         check("model_an", 16'(an), 16'(exp_an));
         check("model_ready", 16'(upd_ready), 16'(m_ready));
         check("model_frame_done", 16'(frame_done), 16'(exp_fd));
      end
   end

   task automatic goto(input int target);
      for (int i = 0; i < 2000 && k != target; i++) @(negedge clk);
      if (k != target) begin
         n_vec++;
         n_err++;
         $display("FAIL goto_timeout: reached k=%0d, expected k=%0d", k, target);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] m,
                        input logic [3:0] b);
      upd_valid = v;
      upd_data  = d;
      upd_mask  = m;
`ifdef DIMMING_EN
      bright    = b;
`else
      if (b != b) upd_valid = v;
`endif
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_segs", 16'(segs), 16'h7F);
      check("rst_an", 16'(an), 16'hF);
      check("rst_ready", 16'(upd_ready), 16'h0);
      rst = 1'b0;
      goto(1);  check("ready_after_rst", 16'(upd_ready), 16'h1);
      goto(5);  check("dark_first_frame", 16'(an), 16'hF);
      goto(10); drive(1'b1, 16'h3210, 4'hF, 4'hF);
      goto(11); drive(1'b0, 16'h0000, 4'h0, 4'h0);
      check("ready_drop", 16'(upd_ready), 16'h0);
      goto(12); drive(1'b1, 16'hFEDC, 4'b0101, 4'hF);
      goto(20); check("held_not_taken", 16'(upd_ready), 16'h0);
      goto(31); check("fd_pulse", 16'(frame_done), 16'h1);
      check("ready_still_low", 16'(upd_ready), 16'h0);
      goto(32); check("ready_after_fd", 16'(upd_ready), 16'h1);
      goto(33); drive(1'b0, 16'h0000, 4'h0, 4'h0);
      check("blank_an", 16'(an), 16'hF);
      check("blank_segs", 16'(segs), 16'h7F);
      goto(35); check("s0_an", 16'(an), 16'hE);  check("s0_segs", 16'(segs), 16'h01);
      goto(43); check("s1_an", 16'(an), 16'hD);  check("s1_segs", 16'(segs), 16'h4F);
      goto(51); check("s2_an", 16'(an), 16'hB);  check("s2_segs", 16'(segs), 16'h12);
      goto(59); check("s3_an", 16'(an), 16'h7);  check("s3_segs", 16'(segs), 16'h06);
      goto(67); check("m_s0_an", 16'(an), 16'hE); check("m_s0_segs", 16'(segs), 16'h31);
      goto(75); check("m_s1_off", 16'(an), 16'hF);
      goto(83); check("m_s2_an", 16'(an), 16'hB); check("m_s2_segs", 16'(segs), 16'h30);
      goto(91); check("m_s3_off", 16'(an), 16'hF);
      goto(95); check("fd_cycle_ready", 16'(upd_ready), 16'h1);
      drive(1'b1, 16'h0B5A, 4'hF, 4'h4);
      goto(96); drive(1'b0, 16'h0000, 4'h0, 4'h0);
      check("fd_accept", 16'(upd_ready), 16'h0);
      goto(99); check("old_kept_an", 16'(an), 16'hE); check("old_kept_segs", 16'(segs), 16'h31);
      goto(131); check("late_s0_an", 16'(an), 16'hE); check("late_s0_segs", 16'(segs), 16'h08);
      goto(135);
`ifdef DIMMING_EN
      check("dim_off_an", 16'(an), 16'hF);
`else
      check("full_on_an", 16'(an), 16'hE);
`endif
      goto(136); drive(1'b1, 16'h1111, 4'hF, 4'hF);
      goto(137); drive(1'b0, 16'h0000, 4'h0, 4'h0);
      goto(139); check("late_s1_an", 16'(an), 16'hD); check("late_s1_segs", 16'(segs), 16'h24);
      goto(146); rst = 1'b1;
      @(negedge clk);
      check("midrst_an", 16'(an), 16'hF);
      check("midrst_segs", 16'(segs), 16'h7F);
      check("midrst_ready", 16'(upd_ready), 16'h0);
      rst = 1'b0;
      goto(40); check("after_rst_dark", 16'(an), 16'hF);
      goto(70); check("after_rst_dark2", 16'(an), 16'hF);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
